// File: rtl/layer_stream_host.sv
// Stream host for a matrix-vector layer: sends an N-word input vector into the
// layer, collects the M result words and reports the transaction latency.
module layer_stream_host #(
  parameter int N       = 4,
  parameter int M       = 8,
  parameter int T       = 16,
  parameter int LOGN    = 2,
  parameter int LOGM    = 3,
  parameter int RDY_GAP = 0,
  parameter int CW      = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ld_wr_en,
  input  logic [LOGN-1:0] ld_addr,
  input  logic [T-1:0]    ld_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   cycles,
  input  logic [LOGM-1:0] rd_addr,
  output logic [T-1:0]    rd_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [T-1:0]    m_data,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [T-1:0]    s_data,
  output logic [1:0]      fsm_state
);

  // Both streams: a beat moves on a rising clk edge where valid and ready are
  // both high; m_valid is held with m_data stable until that edge.
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, RECV = 2'd2, DONE = 2'd3} state_t;

  localparam int GW = (RDY_GAP > 0) ? $clog2(RDY_GAP + 1) : 1;
  localparam logic [LOGN:0] N_LIM = (LOGN + 1)'(N);
  localparam logic [LOGM:0] M_LIM = (LOGM + 1)'(M);

  state_t          state, state_nxt;
  logic [T-1:0]    xbuf [N];
  logic [T-1:0]    ybuf [M];
  logic [LOGN-1:0] xidx;
  logic [LOGM-1:0] yidx;
  logic [GW-1:0]   gap;
  logic [CW-1:0]   cnt, cnt_inc;
  logic            m_fire, s_fire, x_last, y_last;

  assign m_valid   = (state == SEND);
  assign s_ready   = (state == RECV) && (gap == '0);
  assign busy      = (state == SEND) || (state == RECV);
  assign done      = (state == DONE);
  assign m_data    = xbuf[xidx];
  assign m_fire    = m_valid && m_ready;
  assign s_fire    = s_valid && s_ready;
  assign x_last    = (xidx == LOGN'(N - 1));
  assign y_last    = (yidx == LOGM'(M - 1));
  assign cnt_inc   = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
  assign fsm_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEND;
      SEND:    if (m_fire && x_last) state_nxt = RECV;
      RECV:    if (s_fire && y_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      xidx   <= '0;
      yidx   <= '0;
      gap    <= '0;
      cnt    <= '0;
      cycles <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          xidx <= '0;
          yidx <= '0;
          gap  <= '0;
          cnt  <= '0;
        end
        SEND: begin
          cnt <= cnt_inc;
          if (m_fire) xidx <= xidx + 1'b1;
        end
        RECV: begin
          cnt <= cnt_inc;
          // Throttle window restarts after every accepted result word.
          if (s_fire) begin
            yidx <= yidx + 1'b1;
            gap  <= GW'(RDY_GAP);
            if (y_last) cycles <= cnt_inc;
          end else if (gap != '0) begin
            gap <= gap - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer storage carries no reset; writes are blocked while reset is high.
  always_ff @(posedge clk) begin
    if (!reset && state == IDLE && ld_wr_en && ({1'b0, ld_addr} < N_LIM))
      xbuf[ld_addr] <= ld_data;
    if (!reset && s_fire)
      ybuf[yidx] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (reset)
      rd_data <= '0;
    else if ({1'b0, rd_addr} < M_LIM)
      rd_data <= ybuf[rd_addr];
    else
      rd_data <= '0;
  end

endmodule
